// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//
// Receive-side demultiplexer for a time-division serial stream. The
// transmitter sends one bit per slot, slot 0 first, with frame_sync marking
// slot 0. The block tracks the slot index and aligns to the sync marker with
// a HUNT -> CHECK -> LOCK state machine. While locked it presents each
// completed frame as a registered parallel word with a one-cycle strobe.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   din        in   1      serial data bit for the current slot
//   din_valid  in   1      qualifies din and frame_sync
//   frame_sync in   1      marks the slot-0 bit of a frame
//   Y          out  N_CH   recovered frame word, Y[k] = bit from slot k
//   y_valid    out  1      one-cycle pulse when Y updates
//   S          out  SEL_W  slot index expected for the next valid bit
//   locked     out  1      high while in LOCK
//   sync_err   out  1      one-cycle pulse on a sync placement error
// ---------------------------------------------------------------------------
module tdm_demux #(
    parameter int N_CH           = 4,
    parameter int SEL_W          = 2,
    parameter int FRAMES_TO_LOCK = 2,
    parameter int MISS_TO_UNLOCK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [N_CH-1:0]  Y,
    output logic             y_valid,
    output logic [SEL_W-1:0] S,
    output logic             locked,
    output logic             sync_err
);

    localparam int GOOD_W = $clog2(FRAMES_TO_LOCK + 1);
    localparam int MISS_W = $clog2(MISS_TO_UNLOCK + 1);

    localparam logic [SEL_W-1:0]  LAST_SLOT  = SEL_W'(N_CH - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK  = GOOD_W'(FRAMES_TO_LOCK);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MISS_TO_UNLOCK);

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCK
    } state_t;

    state_t            state;
    logic [N_CH-1:0]   frame;
    logic [GOOD_W-1:0] good_cnt;
    logic [MISS_W-1:0] miss_cnt;

    logic              slot0;
    logic              lock_err;
    logic [GOOD_W-1:0] good_next;
    logic [MISS_W-1:0] miss_next;
    logic              unlock;
    logic [N_CH-1:0]   full_frame;

    always_comb begin
        slot0      = (S == '0);
        // In LOCK a sample is wrong if sync is missing at slot 0 or present
        // anywhere else; either case counts as a single miss.
        lock_err   = slot0 ? !frame_sync : frame_sync;
        good_next  = good_cnt + 1'b1;
        miss_next  = miss_cnt + 1'b1;
        unlock     = lock_err && (miss_next == MISS_LIMIT);
        // The last-slot bit is merged directly so Y updates on the same edge
        // that samples it.
        full_frame            = frame;
        full_frame[LAST_SLOT] = din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= HUNT;
            frame    <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
            S        <= '0;
            Y        <= '0;
            y_valid  <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            y_valid  <= 1'b0;
            sync_err <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            frame[0] <= din;
                            S        <= SEL_W'(1);
                            good_cnt <= GOOD_W'(1);
                            state    <= CHECK;
                        end
                    end

                    CHECK: begin
                        if (frame_sync) begin
                            // Any sync restarts a frame at slot 0; only a
                            // correctly placed one advances toward lock.
                            frame[0] <= din;
                            S        <= SEL_W'(1);
                            if (slot0) begin
                                good_cnt <= good_next;
                                if (good_next == GOOD_LOCK) begin
                                    state    <= LOCK;
                                    locked   <= 1'b1;
                                    miss_cnt <= '0;
                                end
                            end else begin
                                sync_err <= 1'b1;
                                good_cnt <= GOOD_W'(1);
                            end
                        end else if (slot0) begin
                            sync_err <= 1'b1;
                            S        <= '0;
                            state    <= HUNT;
                        end else begin
                            frame[S] <= din;
                            S        <= S + 1'b1;
                        end
                    end

                    LOCK: begin
                        if (lock_err) begin
                            sync_err <= 1'b1;
                        end
                        if (unlock) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            S        <= '0;
                            miss_cnt <= '0;
                            frame    <= '0;
                        end else begin
                            // Counter free-runs; syncs never realign it here.
                            frame[S] <= din;
                            S        <= S + 1'b1;
                            if (lock_err) begin
                                miss_cnt <= miss_next;
                            end else if (slot0) begin
                                miss_cnt <= '0;
                            end
                            if (S == LAST_SLOT) begin
                                Y       <= full_frame;
                                y_valid <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state <= HUNT;
                        S     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux
//
// Self-checking bench for tdm_demux. A 4-channel instance covers locking,
// gapped valid, misplaced syncs, unlock and mid-frame reset; an 8-channel
// instance covers slot counter wrap. Expected frame words are queued when
// the stimulus that should deliver them is driven and popped when y_valid
// pulses.
// ---------------------------------------------------------------------------
module tb_tdm_demux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       din4 = 1'b0, dv4 = 1'b0, fs4 = 1'b0;
    logic [3:0] Y4;
    logic       yv4, lk4, se4;
    logic [1:0] S4;

    logic       din8 = 1'b0, dv8 = 1'b0, fs8 = 1'b0;
    logic [7:0] Y8;
    logic       yv8, lk8, se8;
    logic [2:0] S8;

    int checks = 0;
    int errors = 0;
    int err4   = 0;
    time last_t4 = 0, prev_t4 = 0;

    logic [3:0] q4[$];
    logic [7:0] q8[$];

    always #5 clk = ~clk;

    tdm_demux #(.N_CH(4), .SEL_W(2), .FRAMES_TO_LOCK(2), .MISS_TO_UNLOCK(2)) u4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(dv4), .frame_sync(fs4),
        .Y(Y4), .y_valid(yv4), .S(S4), .locked(lk4), .sync_err(se4)
    );

    tdm_demux #(.N_CH(8), .SEL_W(3), .FRAMES_TO_LOCK(2), .MISS_TO_UNLOCK(2)) u8 (
        .clk(clk), .rst_n(rst_n), .din(din8), .din_valid(dv8), .frame_sync(fs8),
        .Y(Y8), .y_valid(yv8), .S(S8), .locked(lk8), .sync_err(se8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare every delivered word against the queue head.
    always @(negedge clk) begin
        if (se4) err4++;
        if (yv4) begin
            prev_t4 = last_t4;
            last_t4 = $time;
            if (q4.size() == 0) check("y4_unexpected", 32'(Y4), 32'hFFFF_FFFF);
            else check("y4_word", 32'(Y4), 32'(q4.pop_front()));
        end
        if (yv8) begin
            if (q8.size() == 0) check("y8_unexpected", 32'(Y8), 32'hFFFF_FFFF);
            else check("y8_word", 32'(Y8), 32'(q8.pop_front()));
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic b, input logic sy);
        din4 = b; fs4 = sy; dv4 = 1'b1;
        @(posedge clk); #1;
        dv4 = 1'b0; fs4 = 1'b0;
    endtask

    task automatic idle_check();
        logic [1:0] s_before;
        s_before = S4;
        dv4 = 1'b0; din4 = ~din4; fs4 = 1'b1;
        @(posedge clk); #1;
        fs4 = 1'b0;
        check("gap_S_hold", 32'(S4), 32'(s_before));
    endtask

    task automatic send_frame(input logic [3:0] w, input logic sync_ok,
                              input logic gap, input logic push);
        for (int k = 0; k < 4; k++) begin
            if (k == 3 && push) q4.push_back(w);
            drive(w[k], (k == 0) && sync_ok);
            if (gap) idle_check();
        end
    endtask

    initial begin
        // Reset state
        dv4 = 1'b1; fs4 = 1'b1; din4 = 1'b1;
        do_reset();
        dv4 = 1'b0; fs4 = 1'b0;
        check("rst_Y", 32'(Y4), 0);
        check("rst_yv", 32'(yv4), 0);
        check("rst_S", 32'(S4), 0);
        check("rst_locked", 32'(lk4), 0);
        check("rst_err", 32'(se4), 0);

        // Lock and recover, continuous valid
        send_frame(4'b1010, 1'b1, 1'b0, 1'b0);
        check("lock_after1", 32'(lk4), 0);
        drive(1'b0, 1'b1);
        check("lock_after2", 32'(lk4), 1);
        q4.push_back(4'b1010);
        drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
        send_frame(4'b1010, 1'b1, 1'b0, 1'b1);
        #10;
        check("spacing_cont", 32'(last_t4 - prev_t4), 40);
        check("Y_hold", 32'(Y4), 32'hA);
        check("errs_clean", 32'(err4), 0);

        // Gapped valid
        do_reset();
        send_frame(4'b1010, 1'b1, 1'b1, 1'b0);
        send_frame(4'b1010, 1'b1, 1'b1, 1'b1);
        send_frame(4'b1010, 1'b1, 1'b1, 1'b1);
        check("spacing_gap", 32'(last_t4 - prev_t4), 80);
        check("gap_locked", 32'(lk4), 1);

        // Misplaced sync in CHECK
        do_reset();
        err4 = 0;
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        check("mis_S", 32'(S4), 1);
        check("mis_err", 32'(se4), 1);
        drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
        check("mis_notlocked", 32'(lk4), 0);
        check("mis_err_cnt", 32'(err4), 1);
        send_frame(4'b0110, 1'b1, 1'b0, 1'b1);
        check("mis_locked", 32'(lk4), 1);

        // Unlock in LOCK after two consecutive missing syncs
        err4 = 0;
        send_frame(4'b1001, 1'b0, 1'b0, 1'b1);
        check("miss1_locked", 32'(lk4), 1);
        drive(1'b1, 1'b0);
        check("miss2_locked", 32'(lk4), 0);
        check("miss2_S", 32'(S4), 0);
        drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        check("miss2_S_hunt", 32'(S4), 0);
        check("miss_err_cnt", 32'(err4), 2);

        // Reset mid-frame while locked
        send_frame(4'b0011, 1'b1, 1'b0, 1'b0);
        send_frame(4'b1100, 1'b1, 1'b0, 1'b1);
        check("relock", 32'(lk4), 1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        din4 = 1'b1; dv4 = 1'b1; fs4 = 1'b0;
        do_reset();
        dv4 = 1'b0;
        check("mrst_Y", 32'(Y4), 0);
        check("mrst_locked", 32'(lk4), 0);
        check("mrst_S", 32'(S4), 0);
        check("mrst_yv", 32'(yv4), 0);
        drive(1'b1, 1'b0);
        check("mrst_hunt_S", 32'(S4), 0);
        send_frame(4'b0101, 1'b1, 1'b0, 1'b0);
        check("mrst_lock1", 32'(lk4), 0);
        send_frame(4'b0101, 1'b1, 1'b0, 1'b1);
        check("mrst_lock2", 32'(lk4), 1);

        // Wrap with 8 channels
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                logic [7:0] w;
                w = 8'hA5;
                if (f == 1 && k == 7) q8.push_back(w);
                din8 = w[k]; fs8 = (k == 0); dv8 = 1'b1;
                @(posedge clk); #1;
                dv8 = 1'b0; fs8 = 1'b0;
                if (f == 1) check("wrap_S", 32'(S8), 32'((k + 1) % 8));
            end
        end
        #20;
        check("wrap_Y", 32'(Y8), 32'hA5);
        check("q4_drained", 32'(q4.size()), 0);
        check("q8_drained", 32'(q8.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
